// File: rtl/dctq_core.sv
// dctq_core: 8x8 forward DCT with a single shared MAC (row pass, then column pass), optional JPEG quantizer (DCTQ_QUANT_EN).
// Latency: start sampled at edge 0 -> coefficient addr 0 valid after edge 1025, addr 63 after edge 1088, ready after edge 1089.
// Backpressure: hold stalls the OUT stream (dctq_valid low, addr/dctq frozen); no stall is possible in LOAD/ROW/COL.
module dctq_core (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [63:0] di,
    input  logic        din_valid,
    input  logic [2:0]  wa,
    input  logic [7:0]  be,
    input  logic        hold,
    output logic        ready,
    output logic [8:0]  dctq,
    output logic        dctq_valid,
    output logic [5:0]  addr
);

    typedef enum logic [2:0] {IDLE, LOAD, ROW, COL, OUT} state_t;

    state_t state;
    state_t state_nxt;

    logic [63:0]        in_buf [8];
    logic [63:0]        work   [8];
    logic signed [11:0] y_mem  [64];
    logic [8:0]         res    [64];

    // cnt = {outer, middle, inner}: ROW {y,v,x}, COL {u,v,y}; inner index is the MAC term.
    logic [8:0]         cnt;
    logic signed [23:0] acc;

    logic [7:0]         pix;
    logic [2:0]         k_sel;
    logic signed [11:0] mul_a;
    logic signed [7:0]  mul_b;
    logic signed [19:0] mul_p;
    logic signed [23:0] acc_sum;
    logic signed [23:0] acc_rnd;
    logic signed [11:0] y_val;
    logic signed [15:0] f_val;
    logic signed [15:0] q_full;
    logic [8:0]         q_sat;

`ifdef DCTQ_QUANT_EN
    // round(65536/Q) for the JPEG luminance table, indexed 8*u+v.
    localparam logic [13:0] RECIP [64] = '{
        14'd4096, 14'd5958, 14'd6554, 14'd4096, 14'd2731, 14'd1638, 14'd1285, 14'd1074,
        14'd5461, 14'd5461, 14'd4681, 14'd3449, 14'd2521, 14'd1130, 14'd1092, 14'd1192,
        14'd4681, 14'd5041, 14'd4096, 14'd2731, 14'd1638, 14'd1150, 14'd950,  14'd1170,
        14'd4681, 14'd3855, 14'd2979, 14'd2260, 14'd1285, 14'd753,  14'd819,  14'd1057,
        14'd3641, 14'd2979, 14'd1771, 14'd1170, 14'd964,  14'd601,  14'd636,  14'd851,
        14'd2731, 14'd1872, 14'd1192, 14'd1024, 14'd809,  14'd630,  14'd580,  14'd712,
        14'd1337, 14'd1024, 14'd840,  14'd753,  14'd636,  14'd542,  14'd546,  14'd649,
        14'd910,  14'd712,  14'd690,  14'd669,  14'd585,  14'd655,  14'd636,  14'd662
    };
    logic signed [31:0] qprod;
    logic signed [31:0] qrnd;
`endif

    // C[k][n] = round(128*c(k)*cos((2n+1)k*pi/16)); the cosine argument is folded mod 32 (units of pi/16).
    function automatic logic signed [7:0] dct_coef(input logic [2:0] k, input logic [2:0] n);
        logic [4:0]        m;
        logic signed [7:0] c;
        m = {1'b0, n, 1'b1} * {2'b00, k};
        case (m[3:0])
            4'd1:    c = 8'sd126;
            4'd2:    c = 8'sd118;
            4'd3:    c = 8'sd106;
            4'd4:    c = 8'sd91;
            4'd5:    c = 8'sd71;
            4'd6:    c = 8'sd49;
            4'd7:    c = 8'sd25;
            4'd9:    c = -8'sd25;
            4'd10:   c = -8'sd49;
            4'd11:   c = -8'sd71;
            4'd12:   c = -8'sd91;
            4'd13:   c = -8'sd106;
            4'd14:   c = -8'sd118;
            4'd15:   c = -8'sd126;
            default: c = 8'sd0;
        endcase
        if (m[4]) c = -c;
        if (k == 3'd0) c = 8'sd91;
        return c;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = ROW;
            ROW:     if (&cnt) state_nxt = COL;
            COL:     if (&cnt) state_nxt = OUT;
            OUT:     if (!hold && addr == 6'd63) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Input row buffer: byte-masked writes accepted in every state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 8; r++) in_buf[r] <= '0;
        end else if (din_valid) begin
            for (int b = 0; b < 8; b++)
                if (!be[b]) in_buf[wa][8*b +: 8] <= di[8*b +: 8];
        end
    end

    // Snapshot the buffer so later host writes cannot disturb the block in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 8; r++) work[r] <= '0;
        end else if (state == LOAD) begin
            for (int r = 0; r < 8; r++) work[r] <= in_buf[r];
        end
    end

    // Shared MAC operand selection, rounding and quantization.
    always_comb begin
        pix = work[cnt[8:6]][{cnt[2:0], 3'b000} +: 8];
        if (state == ROW) begin
            mul_a = $signed({4'b0000, pix} - 12'd128);
            k_sel = cnt[5:3];
        end else begin
            mul_a = y_mem[{cnt[2:0], cnt[5:3]}];
            k_sel = cnt[8:6];
        end
        mul_b   = dct_coef(k_sel, cnt[2:0]);
        mul_p   = mul_a * mul_b;
        acc_sum = acc + 24'(mul_p);
        acc_rnd = acc_sum + 24'sd128;
        y_val   = 12'(acc_rnd >>> 8);
        f_val   = 16'(acc_rnd >>> 8);
`ifdef DCTQ_QUANT_EN
        qprod   = f_val * $signed({2'b00, RECIP[cnt[8:3]]});
        qrnd    = qprod + 32'sd32768;
        q_full  = 16'(qrnd >>> 16);
`else
        q_full  = f_val;
`endif
        if (q_full > 16'sd255)       q_sat = 9'h0FF;
        else if (q_full < -16'sd256) q_sat = 9'h100;
        else                         q_sat = q_full[8:0];
    end

    // Row/column passes: one MAC per cycle, result written on the 8th term.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            acc <= '0;
            for (int i = 0; i < 64; i++) begin
                y_mem[i] <= '0;
                res[i]   <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    cnt <= '0;
                    acc <= '0;
                end
                ROW, COL: begin
                    cnt <= cnt + 9'd1;
                    if (cnt[2:0] == 3'd7) begin
                        acc <= '0;
                        if (state == ROW) y_mem[cnt[8:3]] <= y_val;
                        else              res[cnt[8:3]]   <= q_sat;
                    end else begin
                        acc <= acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered output stream; addr 0 is presented on the last COL edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready      <= 1'b1;
            dctq       <= '0;
            dctq_valid <= 1'b0;
            addr       <= '0;
        end else begin
            case (state)
                IDLE: if (start) ready <= 1'b0;
                COL: if (&cnt) begin
                    dctq       <= res[0];
                    dctq_valid <= 1'b1;
                    addr       <= '0;
                end
                OUT: begin
                    if (hold) begin
                        dctq_valid <= 1'b0;
                    end else if (addr == 6'd63) begin
                        dctq_valid <= 1'b0;
                        addr       <= '0;
                        ready      <= 1'b1;
                    end else begin
                        addr       <= addr + 6'd1;
                        dctq       <= res[addr + 6'd1];
                        dctq_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dctq_core.sv
// tb_dctq_core: directed bench for dctq_core with a floating-point-derived reference model.
// Latency: checks first coefficient after edge 1025 and ready after edge 1089 (+hold cycles).
// Backpressure: exercises a 5-cycle hold at addr 10 and start held high across blocks.
`timescale 1ns/1ps
module tb_dctq_core;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [63:0] di = '0;
    logic        din_valid = 1'b0;
    logic [2:0]  wa = '0;
    logic [7:0]  be = 8'hFF;
    logic        hold = 1'b0;
    logic        ready;
    logic [8:0]  dctq;
    logic        dctq_valid;
    logic [5:0]  addr;

    int n_checks = 0;
    int n_fail = 0;

    int px [8][8];
    int ctab [8][8];
    int exp_q [64];
    int got [64];
    int nvalid, first_valid, ready_edge, order_bad, hold_obs, hold_bad;

    int qtab [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };

`ifdef DCTQ_QUANT_EN
    localparam int DC_FF = 64;
    localparam int DC_00 = -65;
`else
    localparam int DC_FF = 255;
    localparam int DC_00 = -256;
`endif

    dctq_core dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .di         (di),
        .din_valid  (din_valid),
        .wa         (wa),
        .be         (be),
        .hold       (hold),
        .ready      (ready),
        .dctq       (dctq),
        .dctq_valid (dctq_valid),
        .addr       (addr)
    );

    always #5 clk = ~clk;

    task automatic build_ctab();
        real pi, ck, v;
        pi = 3.14159265358979;
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 8; n++) begin
                ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
                v  = 128.0 * ck * $cos((2.0 * n + 1.0) * k * pi / 16.0);
                ctab[k][n] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
            end
        end
    endtask

    task automatic compute_model();
        int yy [8][8];
        int s, f, q, r;
        for (int y = 0; y < 8; y++)
            for (int v = 0; v < 8; v++) begin
                s = 0;
                for (int x = 0; x < 8; x++) s += (px[y][x] - 128) * ctab[v][x];
                yy[y][v] = (s + 128) >>> 8;
            end
        for (int u = 0; u < 8; u++)
            for (int v = 0; v < 8; v++) begin
                s = 0;
                for (int y = 0; y < 8; y++) s += ctab[u][y] * yy[y][v];
                f = (s + 128) >>> 8;
`ifdef DCTQ_QUANT_EN
                r = (65536 + qtab[8*u+v] / 2) / qtab[8*u+v];
                q = (f * r + 32768) >>> 16;
`else
                r = 0;
                q = f + r;
`endif
                if (q > 255) q = 255;
                if (q < -256) q = -256;
                exp_q[8*u+v] = q;
            end
    endtask

    task automatic write_row(input int r, input logic [63:0] d, input logic [7:0] en_n);
        @(negedge clk);
        wa = 3'(r); di = d; be = en_n; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0; be = 8'hFF;
        for (int k = 0; k < 8; k++) if (!en_n[k]) px[r][k] = int'(d[8*k +: 8]);
    endtask

    task automatic fill(input logic [7:0] b);
        for (int r = 0; r < 8; r++) write_row(r, {8{b}}, 8'h00);
    endtask

    task automatic set_dc_only(input int dc);
        for (int i = 0; i < 64; i++) exp_q[i] = 0;
        exp_q[0] = dc;
    endtask

    // Pulse start, then collect the output stream edge by edge (edge 0 = start sample).
    task automatic run_block(input int hold_addr, input int hold_len, input bit scribble);
        for (int i = 0; i < 64; i++) got[i] = 9999;
        nvalid = 0; first_valid = -1; ready_edge = -1; order_bad = 0; hold_obs = 0; hold_bad = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL ready_drop: got %b want 0", ready); end
        for (int e = 1; e <= 1400; e++) begin
            if (scribble && e >= 5 && e < 13) begin
                wa = 3'(e - 5); di = '1; be = 8'h00; din_valid = 1'b1;
            end else begin
                din_valid = 1'b0; be = 8'hFF;
            end
            @(posedge clk);
            @(negedge clk);
            if (hold) begin
                hold_obs++;
                if (dctq_valid !== 1'b0 || int'(addr) != hold_addr) hold_bad++;
                if (hold_obs == hold_len) hold = 1'b0;
            end else if (dctq_valid === 1'b1) begin
                if (first_valid < 0) first_valid = e;
                if (int'(addr) != nvalid) order_bad++;
                got[addr] = int'($signed(dctq));
                nvalid++;
                if (hold_len > 0 && hold_obs == 0 && int'(addr) == hold_addr) hold = 1'b1;
            end
            if (ready === 1'b1) begin ready_edge = e; break; end
        end
        din_valid = 1'b0; be = 8'hFF; hold = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", ready); end
        n_checks++; if (dctq_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", dctq_valid); end
        n_checks++; if (addr !== 6'd0) begin n_fail++; $display("FAIL rst_addr: got %0d want 0", addr); end
        n_checks++; if (dctq !== 9'd0) begin n_fail++; $display("FAIL rst_dctq: got %0d want 0", dctq); end
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        for (int r = 0; r < 8; r++) for (int k = 0; k < 8; k++) px[r][k] = 0;
    endtask

    task automatic test_flat_128();
        fill(8'h80);
        set_dc_only(0);
        run_block(-1, 0, 1'b0);
        n_checks++; if (first_valid != 1025) begin n_fail++; $display("FAIL f128_first: got %0d want 1025", first_valid); end
        n_checks++; if (ready_edge != 1089) begin n_fail++; $display("FAIL f128_ready: got %0d want 1089", ready_edge); end
        n_checks++; if (nvalid != 64 || order_bad != 0) begin n_fail++; $display("FAIL f128_order: got %0d/%0d want 64/0", nvalid, order_bad); end
        for (int i = 0; i < 64; i++) begin
            n_checks++;
            if (got[i] != exp_q[i]) begin n_fail++; $display("FAIL f128_coef[%0d]: got %0d want %0d", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_flat_ff();
        fill(8'hFF);
        set_dc_only(DC_FF);
        run_block(-1, 0, 1'b0);
        n_checks++; if (first_valid != 1025 || ready_edge != 1089) begin n_fail++; $display("FAIL fff_timing: got %0d/%0d want 1025/1089", first_valid, ready_edge); end
        for (int i = 0; i < 64; i++) begin
            n_checks++;
            if (got[i] != exp_q[i]) begin n_fail++; $display("FAIL fff_coef[%0d]: got %0d want %0d", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_flat_00();
        fill(8'h00);
        set_dc_only(DC_00);
        run_block(-1, 0, 1'b0);
        n_checks++; if (nvalid != 64 || order_bad != 0) begin n_fail++; $display("FAIL f00_order: got %0d/%0d want 64/0", nvalid, order_bad); end
        for (int i = 0; i < 64; i++) begin
            n_checks++;
            if (got[i] != exp_q[i]) begin n_fail++; $display("FAIL f00_coef[%0d]: got %0d want %0d", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_single_pixel();
        fill(8'h80);
        write_row(0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFE);
        compute_model();
        run_block(-1, 0, 1'b0);
        n_checks++; if (first_valid != 1025 || ready_edge != 1089) begin n_fail++; $display("FAIL pix_timing: got %0d/%0d want 1025/1089", first_valid, ready_edge); end
        for (int i = 0; i < 64; i++) begin
            n_checks++;
            if (got[i] != exp_q[i]) begin n_fail++; $display("FAIL pix_coef[%0d]: got %0d want %0d", i, got[i], exp_q[i]); end
        end
    endtask

    // Same single-pixel block, buffer overwritten mid-block, 5-cycle hold at addr 10.
    task automatic test_hold_snapshot();
        compute_model();
        run_block(10, 5, 1'b1);
        n_checks++; if (hold_obs != 5 || hold_bad != 0) begin n_fail++; $display("FAIL hold_stall: got %0d/%0d want 5/0", hold_obs, hold_bad); end
        n_checks++; if (ready_edge != 1094) begin n_fail++; $display("FAIL hold_ready: got %0d want 1094", ready_edge); end
        n_checks++; if (nvalid != 64 || order_bad != 0) begin n_fail++; $display("FAIL hold_order: got %0d/%0d want 64/0", nvalid, order_bad); end
        for (int i = 0; i < 64; i++) begin
            n_checks++;
            if (got[i] != exp_q[i]) begin n_fail++; $display("FAIL hold_coef[%0d]: got %0d want %0d", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_restart();
        int seen;
        seen = -1;
        @(negedge clk); start = 1'b1;
        for (int e = 0; e < 1300; e++) begin
            @(negedge clk);
            if (ready === 1'b1) begin seen = e; break; end
        end
        n_checks++; if (seen != 1089) begin n_fail++; $display("FAIL restart_ready: got %0d want 1089", seen); end
        @(negedge clk);
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL restart_relaunch: got %b want 0", ready); end
        start = 1'b0;
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic test_reset_abort();
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (600) @(posedge clk);
        @(negedge clk);
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", ready); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (ready !== 1'b1 || dctq_valid !== 1'b0) begin n_fail++; $display("FAIL abort_rst: got ready=%b valid=%b want 1/0", ready, dctq_valid); end
        n_checks++; if (addr !== 6'd0 || dctq !== 9'd0) begin n_fail++; $display("FAIL abort_outs: got addr=%0d dctq=%0d want 0/0", addr, dctq); end
        @(negedge clk); reset_n = 1'b1;
        set_dc_only(DC_00);
        run_block(-1, 0, 1'b0);
        n_checks++; if (first_valid != 1025 || ready_edge != 1089) begin n_fail++; $display("FAIL abort_timing: got %0d/%0d want 1025/1089", first_valid, ready_edge); end
        for (int i = 0; i < 64; i++) begin
            n_checks++;
            if (got[i] != exp_q[i]) begin n_fail++; $display("FAIL abort_coef[%0d]: got %0d want %0d", i, got[i], exp_q[i]); end
        end
    endtask

    initial begin
        build_ctab();
        test_reset();
        test_flat_128();
        test_flat_ff();
        test_flat_00();
        test_single_pixel();
        test_hold_snapshot();
        test_restart();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
